// File: rtl/xyz_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : xyz_reg_ctrl
// Brief   : Register bank owner with reset-time INIT sequencing and
//           round-robin sharing between a bus frontdoor (m0) and a debug
//           backdoor (m1). Optional per-register parity: XYZ_REG_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module xyz_reg_ctrl #(
  parameter int              NREGS     = 2,
  parameter int              AW        = 1,
  parameter int              DW        = 32,
  parameter logic [DW-1:0]   RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          r,
`ifdef XYZ_REG_PARITY_EN
  input  logic          par_inj,
`endif
  output logic          busy,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_nxt;
  logic [DW-1:0]   r_bank [NREGS];
  logic            r_rr_ptr;

  logic            r_m0_rvalid, r_m1_rvalid;
  logic [DW-1:0]   r_m0_rdata,  r_m1_rdata;
  logic            r_m0_err,    r_m1_err;

  logic            w_ok, w_gnt0, w_gnt1, w_any;
  logic            w_we, w_in_range, w_rd_err;
  logic [AW-1:0]   w_addr;
  logic [IW-1:0]   w_ridx;
  logic [DW-1:0]   w_wdata, w_rd_word;

  // Grants are combinational; r gates them so the edge coincident with reset never transfers.
  assign w_ok   = (r_state == ST_RUN) && !r;
  assign w_gnt0 = w_ok && m0_req && (!m1_req || !r_rr_ptr);
  assign w_gnt1 = w_ok && m1_req && (!m0_req ||  r_rr_ptr);
  assign w_any  = w_gnt0 || w_gnt1;

  assign w_we       = w_gnt1 ? m1_we    : m0_we;
  assign w_addr     = w_gnt1 ? m1_addr  : m0_addr;
  assign w_wdata    = w_gnt1 ? m1_wdata : m0_wdata;
  assign w_in_range = (32'(w_addr) < 32'(NREGS));
  assign w_ridx     = w_addr[IW-1:0];
  assign w_rd_word  = r_bank[w_ridx];

`ifdef XYZ_REG_PARITY_EN
  logic r_par [NREGS];
  assign w_rd_err = (^w_rd_word) != r_par[w_ridx];
`else
  assign w_rd_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (r_state == ST_INIT) begin
      w_idx_nxt = r_idx + 1'b1;
      if (r_idx == IW'(NREGS - 1)) begin
        w_state_nxt = ST_RUN;
        w_idx_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Bank contents survive r; INIT is what brings them to RESET_VAL.
  always_ff @(posedge clk) begin
    if (!r) begin
      if (r_state == ST_INIT) begin
        r_bank[r_idx] <= RESET_VAL;
`ifdef XYZ_REG_PARITY_EN
        r_par[r_idx]  <= ^RESET_VAL;
`endif
      end else if (w_any && w_we && w_in_range) begin
        r_bank[w_ridx] <= w_wdata;
`ifdef XYZ_REG_PARITY_EN
        r_par[w_ridx]  <= (^w_wdata) ^ par_inj;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      r_rr_ptr    <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_m0_err    <= 1'b0;
      r_m1_err    <= 1'b0;
    end else begin
      r_m0_rvalid <= w_gnt0;
      r_m1_rvalid <= w_gnt1;
      r_m0_rdata  <= (w_gnt0 && !w_we && w_in_range) ? w_rd_word : '0;
      r_m1_rdata  <= (w_gnt1 && !w_we && w_in_range) ? w_rd_word : '0;
      r_m0_err    <= w_gnt0 && (!w_in_range || (!w_we && w_rd_err));
      r_m1_err    <= w_gnt1 && (!w_in_range || (!w_we && w_rd_err));
      if (w_gnt0) begin
        r_rr_ptr <= 1'b1;
      end else if (w_gnt1) begin
        r_rr_ptr <= 1'b0;
      end
    end
  end

  assign busy      = r || (r_state == ST_INIT);
  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign m0_err    = r_m0_err;
  assign m1_err    = r_m1_err;

endmodule
`default_nettype wire
